// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the RV32I memory stage: datapath width, funct3 access
// codes, result-source selects and the bus FSM state encoding.
package mem_stage_lsu_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
   localparam logic [1:0] RESULT_SRC_PC4  = 2'b10;
   localparam logic [1:0] RESULT_SRC_IMM  = 2'b11;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUS  = 1'b1
   } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
interface mem_stage_lsu_if;
   import mem_stage_lsu_pkg::*;

   logic            req;
   logic            we;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic [3:0]      be;
   logic            ack;
   logic [XLEN-1:0] rdata;

   modport master (output req, we, addr, wdata, be, input ack, rdata);
   modport slave  (input req, we, addr, wdata, be, output ack, rdata);

endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational alignment helper: store lane steering and byte enables,
// load byte/half extraction with extension, and misaligned/illegal detection.
module lsu_align
   import mem_stage_lsu_pkg::*;
(
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_addr_lo,
   input  logic            i_is_store,
   input  logic [XLEN-1:0] i_store_data,
   output logic [3:0]      o_be,
   output logic [XLEN-1:0] o_wdata,
   output logic            o_bad,
   input  logic [2:0]      i_ld_funct3,
   input  logic [1:0]      i_ld_off,
   input  logic [XLEN-1:0] i_rdata,
   output logic [XLEN-1:0] o_load_data
);

   logic            w_illegal;
   logic            w_misal;
   logic [XLEN-1:0] w_shifted;

   always_comb begin
      w_illegal = 1'b1;
      w_misal   = 1'b0;
      o_be      = 4'b1111;
      o_wdata   = i_store_data;
      if (i_is_store) begin
         case (i_funct3)
            F3_B: begin
               w_illegal = 1'b0;
               o_be      = 4'b0001 << i_addr_lo;
               o_wdata   = {4{i_store_data[7:0]}};
            end
            F3_H: begin
               w_illegal = 1'b0;
               o_be      = 4'b0011 << i_addr_lo;
               o_wdata   = {2{i_store_data[15:0]}};
            end
            F3_W:    w_illegal = 1'b0;
            default: w_illegal = 1'b1;
         endcase
      end else begin
         case (i_funct3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: w_illegal = 1'b0;
            default:                        w_illegal = 1'b1;
         endcase
      end
      case (i_funct3[1:0])
         2'b01:   w_misal = i_addr_lo[0];
         2'b10:   w_misal = |i_addr_lo;
         default: w_misal = 1'b0;
      endcase
      o_bad = w_illegal | w_misal;
   end

   // The wanted byte/half is moved down to bit 0 before extension.
   always_comb begin
      w_shifted = i_rdata >> {i_ld_off, 3'b000};
      case (i_ld_funct3)
         F3_B:    o_load_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
         F3_BU:   o_load_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
         F3_H:    o_load_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
         F3_HU:   o_load_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
         default: o_load_data = w_shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32I memory stage: drives the data-memory bus with a req/ack handshake,
// stalls upstream while an access is outstanding, and holds the MEM/WB register.
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_valid,
   input  logic            i_reg_write,
   input  logic [1:0]      i_result_src,
   input  logic            i_mem_write,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_alu_result,
   input  logic [XLEN-1:0] i_write_data,
   input  logic [XLEN-1:0] i_pc_plus4,
   input  logic [XLEN-1:0] i_ext_imm,
   input  logic [4:0]      i_rd,
   mem_stage_lsu_if.master dmem,
   output logic            o_stall,
   output logic            o_wb_valid,
   output logic            o_wb_reg_write,
   output logic [4:0]      o_wb_rd,
   output logic [XLEN-1:0] o_wb_result,
   output logic            o_misaligned,
   output logic            o_bus_err
);

   localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);

   lsu_state_t      r_state, w_next_state;
   logic [7:0]      r_cnt;
   logic [XLEN-1:0] r_addr, r_wdata;
   logic [3:0]      r_be;
   logic            r_we, r_reg_write;
   logic [2:0]      r_funct3;
   logic [1:0]      r_off;
   logic [4:0]      r_rd;

   logic            w_mem_op, w_bad, w_accept, w_done, w_timeout;
   logic [3:0]      w_be;
   logic [XLEN-1:0] w_wdata, w_load_data, w_result;

   assign w_mem_op = i_valid & (i_mem_write | (i_result_src == RESULT_SRC_LOAD));

   lsu_align u_align (
      .i_funct3     (i_funct3),
      .i_addr_lo    (i_alu_result[1:0]),
      .i_is_store   (i_mem_write),
      .i_store_data (i_write_data),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_bad        (w_bad),
      .i_ld_funct3  (r_funct3),
      .i_ld_off     (r_off),
      .i_rdata      (dmem.rdata),
      .o_load_data  (w_load_data)
   );

   assign dmem.we    = r_we;
   assign dmem.addr  = r_addr;
   assign dmem.wdata = r_wdata;
   assign dmem.be    = r_be;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   // Stall is gated by reset so every output reads 0 while reset is held.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_done       = 1'b0;
      w_timeout    = 1'b0;
      o_stall      = 1'b0;
      dmem.req     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_rstn && w_mem_op && !w_bad) begin
               w_accept     = 1'b1;
               o_stall      = 1'b1;
               w_next_state = S_BUS;
            end
         end
         S_BUS: begin
            dmem.req = 1'b1;
            o_stall  = 1'b1;
            if (dmem.ack) begin
               w_done       = 1'b1;
               w_next_state = S_IDLE;
            end else if (r_cnt + 8'd1 == TIMEOUT_VAL) begin
               w_timeout    = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      case (i_result_src)
         RESULT_SRC_PC4: w_result = i_pc_plus4;
         RESULT_SRC_IMM: w_result = i_ext_imm;
         default:        w_result = i_alu_result;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_cnt          <= '0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_be           <= '0;
         r_we           <= 1'b0;
         r_reg_write    <= 1'b0;
         r_funct3       <= '0;
         r_off          <= '0;
         r_rd           <= '0;
         o_wb_valid     <= 1'b0;
         o_wb_reg_write <= 1'b0;
         o_wb_rd        <= '0;
         o_wb_result    <= '0;
         o_misaligned   <= 1'b0;
         o_bus_err      <= 1'b0;
      end else begin
         o_misaligned <= 1'b0;
         o_bus_err    <= 1'b0;
         if (w_accept) begin
            r_cnt          <= '0;
            r_addr         <= {i_alu_result[XLEN-1:2], 2'b00};
            r_wdata        <= w_wdata;
            r_be           <= w_be;
            r_we           <= i_mem_write;
            r_reg_write    <= i_reg_write & ~i_mem_write;
            r_funct3       <= i_funct3;
            r_off          <= i_alu_result[1:0];
            r_rd           <= i_rd;
            o_wb_valid     <= 1'b0;
            o_wb_reg_write <= 1'b0;
         end else if (r_state == S_BUS) begin
            if (w_done || w_timeout) begin
               r_cnt          <= '0;
               o_wb_valid     <= 1'b1;
               o_wb_reg_write <= w_done & r_reg_write;
               o_wb_rd        <= r_rd;
               o_wb_result    <= (w_done && !r_we) ? w_load_data : '0;
               o_bus_err      <= w_timeout;
            end else begin
               r_cnt          <= r_cnt + 8'd1;
               o_wb_valid     <= 1'b0;
               o_wb_reg_write <= 1'b0;
            end
         end else begin
            // In IDLE a memory op that was not accepted must have been bad.
            o_wb_valid     <= i_valid;
            o_wb_reg_write <= i_valid & ~w_mem_op & i_reg_write;
            o_wb_rd        <= i_rd;
            o_wb_result    <= w_mem_op ? '0 : w_result;
            o_misaligned   <= w_mem_op;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu with a hand-driven memory slave.
module tb_mem_stage_lsu;
   import mem_stage_lsu_pkg::*;

   logic            i_clk, i_rstn;
   logic            i_valid, i_reg_write, i_mem_write;
   logic [1:0]      i_result_src;
   logic [2:0]      i_funct3;
   logic [31:0]     i_alu_result, i_write_data, i_pc_plus4, i_ext_imm;
   logic [4:0]      i_rd;
   logic            o_stall, o_wb_valid, o_wb_reg_write, o_misaligned, o_bus_err;
   logic [4:0]      o_wb_rd;
   logic [31:0]     o_wb_result;

   int              checks = 0;
   int              errors = 0;
   int              stallCount, reqCount;
   logic [31:0]     busAddr, busWdata;
   logic [3:0]      busBe;
   logic            busWe;

   mem_stage_lsu_if dmemBus ();

   mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
      .i_clk          (i_clk),
      .i_rstn         (i_rstn),
      .i_valid        (i_valid),
      .i_reg_write    (i_reg_write),
      .i_result_src   (i_result_src),
      .i_mem_write    (i_mem_write),
      .i_funct3       (i_funct3),
      .i_alu_result   (i_alu_result),
      .i_write_data   (i_write_data),
      .i_pc_plus4     (i_pc_plus4),
      .i_ext_imm      (i_ext_imm),
      .i_rd           (i_rd),
      .dmem           (dmemBus),
      .o_stall        (o_stall),
      .o_wb_valid     (o_wb_valid),
      .o_wb_reg_write (o_wb_reg_write),
      .o_wb_rd        (o_wb_rd),
      .o_wb_result    (o_wb_result),
      .o_misaligned   (o_misaligned),
      .o_bus_err      (o_bus_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic rw, input logic [1:0] src,
                                input logic mw, input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] wd, input logic [31:0] pc4,
                                input logic [31:0] imm, input logic [4:0] rd);
      i_valid = v; i_reg_write = rw; i_result_src = src; i_mem_write = mw;
      i_funct3 = f3; i_alu_result = alu; i_write_data = wd;
      i_pc_plus4 = pc4; i_ext_imm = imm; i_rd = rd;
   endtask

   // Presents one memory op, acks in BUS cycle ackCycle (0 = never), and
   // returns just after the edge where req has dropped, with i_valid cleared.
   task automatic runAccess(input logic [2:0] f3, input logic st, input logic [31:0] addr,
                            input logic [31:0] wd, input int ackCycle, input logic [31:0] rdata);
      applyStimulus(1'b1, 1'b1, st ? RESULT_SRC_ALU : RESULT_SRC_LOAD, st, f3, addr, wd,
                    32'h0, 32'h0, 5'd9);
      stallCount = 0;
      reqCount   = 0;
      busAddr = '0; busWdata = '0; busBe = '0; busWe = 1'b0;
      #1;
      if (o_stall) stallCount++;
      for (int c = 1; c <= 20; c++) begin
         @(posedge i_clk); #1;
         if (c == 1) begin
            busAddr = dmemBus.addr; busBe = dmemBus.be;
            busWe = dmemBus.we; busWdata = dmemBus.wdata;
         end
         if (!dmemBus.req) break;
         reqCount++;
         dmemBus.ack   = (c == ackCycle);
         dmemBus.rdata = rdata;
         #1;
         if (o_stall) stallCount++;
      end
      dmemBus.ack = 1'b0;
      i_valid     = 1'b0;
      i_mem_write = 1'b0;
   endtask

   initial begin
      dmemBus.ack = 1'b0;
      dmemBus.rdata = '0;
      i_rstn = 1'b0;
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
      repeat (2) @(posedge i_clk);
      #1;
      checkOutput("rst_wb_valid", 32'(o_wb_valid), 32'h0);
      checkOutput("rst_wb_result", o_wb_result, 32'h0);
      checkOutput("rst_req", 32'(dmemBus.req), 32'h0);
      checkOutput("rst_stall", 32'(o_stall), 32'h0);
      i_rstn = 1'b1;

      // Non-memory ops through each result-mux leg
      applyStimulus(1'b1, 1'b1, RESULT_SRC_ALU, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h88, 32'h55, 5'd5);
      #1 checkOutput("alu_stall", 32'(o_stall), 32'h0);
      @(posedge i_clk); #1;
      checkOutput("alu_result", o_wb_result, 32'h1234);
      checkOutput("alu_rd", 32'(o_wb_rd), 32'd5);
      checkOutput("alu_reg_write", 32'(o_wb_reg_write), 32'h1);
      checkOutput("alu_valid", 32'(o_wb_valid), 32'h1);
      applyStimulus(1'b1, 1'b1, RESULT_SRC_PC4, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h88, 32'h55, 5'd6);
      @(posedge i_clk); #1;
      checkOutput("pc4_result", o_wb_result, 32'h88);
      applyStimulus(1'b1, 1'b0, RESULT_SRC_IMM, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h88, 32'h55, 5'd7);
      @(posedge i_clk); #1;
      checkOutput("imm_result", o_wb_result, 32'h55);
      checkOutput("imm_reg_write", 32'(o_wb_reg_write), 32'h0);
      i_valid = 1'b0;
      @(posedge i_clk); #1;
      checkOutput("bubble_valid", 32'(o_wb_valid), 32'h0);

      // LB / LBU at byte 3, ack in the third BUS cycle
      runAccess(F3_B, 1'b0, 32'h103, 32'h0, 3, 32'h80FF_0000);
      checkOutput("lb_addr", busAddr, 32'h100);
      checkOutput("lb_be", 32'(busBe), 32'hF);
      checkOutput("lb_we", 32'(busWe), 32'h0);
      checkOutput("lb_stall_cycles", 32'(stallCount), 32'd4);
      checkOutput("lb_result", o_wb_result, 32'hFFFF_FF80);
      checkOutput("lb_valid", 32'(o_wb_valid), 32'h1);
      checkOutput("lb_reg_write", 32'(o_wb_reg_write), 32'h1);
      checkOutput("lb_rd", 32'(o_wb_rd), 32'd9);
      #1 checkOutput("lb_stall_released", 32'(o_stall), 32'h0);
      runAccess(F3_BU, 1'b0, 32'h103, 32'h0, 3, 32'h80FF_0000);
      checkOutput("lbu_result", o_wb_result, 32'h0000_0080);
      runAccess(F3_H, 1'b0, 32'h102, 32'h0, 1, 32'h8001_0000);
      checkOutput("lh_result", o_wb_result, 32'hFFFF_8001);

      // SH to the upper half, immediate ack
      runAccess(F3_H, 1'b1, 32'h202, 32'hABCD_1234, 1, 32'h0);
      checkOutput("sh_addr", busAddr, 32'h200);
      checkOutput("sh_be", 32'(busBe), 32'hC);
      checkOutput("sh_wdata", busWdata, 32'h1234_1234);
      checkOutput("sh_we", 32'(busWe), 32'h1);
      checkOutput("sh_reg_write", 32'(o_wb_reg_write), 32'h0);
      checkOutput("sh_valid", 32'(o_wb_valid), 32'h1);
      checkOutput("sh_stall_cycles", 32'(stallCount), 32'd2);
      runAccess(F3_B, 1'b1, 32'h201, 32'h0000_00A5, 1, 32'h0);
      checkOutput("sb_be", 32'(busBe), 32'h2);
      checkOutput("sb_wdata", busWdata, 32'hA5A5_A5A5);

      // Misaligned word load and illegal funct3
      runAccess(F3_W, 1'b0, 32'h301, 32'h0, 1, 32'h0);
      checkOutput("lw_mis_req", 32'(reqCount), 32'd0);
      checkOutput("lw_mis_stall", 32'(stallCount), 32'd0);
      checkOutput("lw_mis_pulse", 32'(o_misaligned), 32'h1);
      checkOutput("lw_mis_valid", 32'(o_wb_valid), 32'h1);
      checkOutput("lw_mis_reg_write", 32'(o_wb_reg_write), 32'h0);
      @(posedge i_clk); #1;
      checkOutput("lw_mis_pulse_end", 32'(o_misaligned), 32'h0);
      runAccess(3'b011, 1'b0, 32'h300, 32'h0, 1, 32'h0);
      checkOutput("ill_req", 32'(reqCount), 32'd0);
      checkOutput("ill_pulse", 32'(o_misaligned), 32'h1);
      checkOutput("ill_reg_write", 32'(o_wb_reg_write), 32'h0);

      // Timeout with TIMEOUT_CYCLES=4
      runAccess(F3_W, 1'b0, 32'h500, 32'h0, 0, 32'h0);
      checkOutput("to_req_cycles", 32'(reqCount), 32'd4);
      checkOutput("to_bus_err", 32'(o_bus_err), 32'h1);
      checkOutput("to_valid", 32'(o_wb_valid), 32'h1);
      checkOutput("to_reg_write", 32'(o_wb_reg_write), 32'h0);
      #1 checkOutput("to_stall", 32'(o_stall), 32'h0);
      @(posedge i_clk); #1;
      checkOutput("to_bus_err_end", 32'(o_bus_err), 32'h0);
      checkOutput("to_idle_req", 32'(dmemBus.req), 32'h0);

      // Asynchronous reset while in BUS
      applyStimulus(1'b1, 1'b1, RESULT_SRC_LOAD, 1'b0, F3_W, 32'h600, 32'h0, 32'h0, 32'h0, 5'd3);
      @(posedge i_clk); #1;
      checkOutput("rb_req_before", 32'(dmemBus.req), 32'h1);
      i_rstn = 1'b0;
      #1;
      checkOutput("rb_req", 32'(dmemBus.req), 32'h0);
      checkOutput("rb_stall", 32'(o_stall), 32'h0);
      checkOutput("rb_addr", dmemBus.addr, 32'h0);
      checkOutput("rb_wb_valid", 32'(o_wb_valid), 32'h0);
      i_valid = 1'b0;
      @(posedge i_clk); #1;
      i_rstn = 1'b1;
      runAccess(F3_W, 1'b0, 32'h400, 32'h0, 2, 32'hDEAD_BEEF);
      checkOutput("post_rst_addr", busAddr, 32'h400);
      checkOutput("post_rst_result", o_wb_result, 32'hDEAD_BEEF);
      checkOutput("post_rst_reg_write", 32'(o_wb_reg_write), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
